// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared types for the RAM-backed FIFO controller: how the occupancy count moves each cycle.
package ram_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // A push and a pop in the same cycle cancel out, so the count only moves on a lone push or pop.
  function automatic cnt_op_e cnt_op(input logic push, input logic pop);
    cnt_op_e op;
    op = CNT_HOLD;
    if (push && !pop) op = CNT_INC;
    else if (pop && !push) op = CNT_DEC;
    return op;
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl.sv
// Pointer/flow-control stage that turns a sync-write, async-read dual-port RAM into a show-ahead FIFO.
// The parent instantiates the RAM beside this block and wires the ram_* ports to it.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  // The extra wrap bit distinguishes full from empty when the address bits coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // The RAM must not capture a word while reset or flush is discarding it.
  assign ram_en      = push && !flush && rst_n;
  assign ram_w_addr  = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_r_addr  = rd_ptr[ADDR_WIDTH-1:0];
  assign ram_data_in = in_data;
  assign out_data    = ram_data_out;

  assign almost_full = (count >= PW'(AF_LEVEL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case (cnt_op(push, pop))
        CNT_INC: if (count != PW'(DEPTH)) count <= count + PW'(1);
        CNT_DEC: if (count != '0)         count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural sync-write/async-read RAM wired alongside.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [4:0] count;
  logic       almost_full;
  logic       ram_en;
  logic [3:0] ram_w_addr;
  logic [3:0] ram_r_addr;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out;

  logic [7:0] mem [16];
  logic [7:0] q [$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_w = 0;

  ram_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .AF_LEVEL(12)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(almost_full),
    .ram_en(ram_en), .ram_w_addr(ram_w_addr), .ram_r_addr(ram_r_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_en) mem[ram_w_addr] <= ram_data_in;
  assign ram_data_out = mem[ram_r_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h33;
    tick();
    tick();
    n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (count !== 5'd0)     begin n_err++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (ram_en !== 1'b0)    begin n_err++; $display("[TB] FAIL reset_ram_en got %b want 0", ram_en); end
    n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("[TB] FAIL reset_almost_full got %b want 0", almost_full); end
    n_cmp++; if (ram_w_addr !== 4'd0 || ram_r_addr !== 4'd0) begin n_err++; $display("[TB] FAIL reset_addrs got w=%0d r=%0d want 0/0", ram_w_addr, ram_r_addr); end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("[TB] FAIL post_reset_count got %0d want 0", count); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      #1;
      n_cmp++; if (ram_en !== 1'b1) begin n_err++; $display("[TB] FAIL fill_ram_en[%0d] got %b want 1", i, ram_en); end
      tick();
      q.push_back(8'(i));
      exp_w++;
      n_cmp++; if (count !== 5'(i + 1)) begin n_err++; $display("[TB] FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
      n_cmp++; if (almost_full !== ((i + 1) >= 12)) begin n_err++; $display("[TB] FAIL fill_almost_full[%0d] got %b want %b", i, almost_full, ((i + 1) >= 12)); end
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL full_in_ready got %b want 0", in_ready); end
    in_data = 8'hAA;
    #1;
    n_cmp++; if (ram_en !== 1'b0) begin n_err++; $display("[TB] FAIL full_refused_ram_en got %b want 0", ram_en); end
    tick();
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("[TB] FAIL full_refused_count got %0d want 16", count); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("[TB] FAIL full_head got %h want 00", out_data); end
    in_valid = 1'b0;
  endtask

  task automatic test_drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'(i)) begin n_err++; $display("[TB] FAIL drain_data[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 8'(i)); end
      tick();
      void'(q.pop_front());
      n_cmp++; if (count !== 5'(15 - i)) begin n_err++; $display("[TB] FAIL drain_count[%0d] got %0d want %0d", i, count, 15 - i); end
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL drain_empty got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h80 + 8'(i);
      tick();
      q.push_back(in_data);
      exp_w++;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = 8'h83 + 8'(k);
      #1;
      exp = q[0];
      n_cmp++; if (out_data !== exp) begin n_err++; $display("[TB] FAIL wrap_data[%0d] got %h want %h", k, out_data, exp); end
      tick();
      q.push_back(in_data);
      void'(q.pop_front());
      exp_w++;
      n_cmp++; if (count !== 5'd3) begin n_err++; $display("[TB] FAIL wrap_count[%0d] got %0d want 3", k, count); end
    end
    n_cmp++; if (ram_w_addr !== 4'(exp_w % 16)) begin n_err++; $display("[TB] FAIL wrap_w_addr got %0d want %0d", ram_w_addr, exp_w % 16); end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_full_boundary();
    logic [7:0] exp;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hC0 + 8'(i);
      tick();
      q.push_back(in_data);
    end
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("[TB] FAIL boundary_setup_count got %0d want 16", count); end
    in_data   = 8'hBB;
    out_ready = 1'b1;
    #1;
    exp = q[0];
    n_cmp++; if (ram_en !== 1'b0) begin n_err++; $display("[TB] FAIL boundary_ram_en got %b want 0", ram_en); end
    n_cmp++; if (out_data !== exp) begin n_err++; $display("[TB] FAIL boundary_head got %h want %h", out_data, exp); end
    tick();
    void'(q.pop_front());
    n_cmp++; if (count !== 5'd15) begin n_err++; $display("[TB] FAIL boundary_count got %0d want 15", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL boundary_in_ready got %b want 1", in_ready); end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [7:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp = q[0];
      n_cmp++; if (out_data !== exp) begin n_err++; $display("[TB] FAIL preflush_data[%0d] got %h want %h", i, out_data, exp); end
      tick();
      void'(q.pop_front());
    end
    out_ready = 1'b0;
    n_cmp++; if (count !== 5'd5) begin n_err++; $display("[TB] FAIL preflush_count got %0d want 5", count); end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    n_cmp++; if (ram_en !== 1'b0) begin n_err++; $display("[TB] FAIL flush_ram_en got %b want 0", ram_en); end
    tick();
    q.delete();
    n_cmp++; if (count !== 5'd0)     begin n_err++; $display("[TB] FAIL flush_count got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL flush_out_valid got %b want 0", out_valid); end
    flush   = 1'b0;
    in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin n_err++; $display("[TB] FAIL postflush_head got v=%b d=%h want v=1 d=5a", out_valid, out_data); end
    n_cmp++; if (count !== 5'd1) begin n_err++; $display("[TB] FAIL postflush_count got %0d want 1", count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_boundary();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
